// File: rtl/heatmap_mem_arbiter.sv
// rtl/heatmap_mem_arbiter.sv - heat-map pixel memory arbiter: VGA reader vs saturating RMW point writer
// Reader has priority; the writer wins after MAX_WAIT consecutive reader grants while it waits.
module heatmap_mem_arbiter #(
   parameter int WIDTH    = 640,
   parameter int HEIGHT   = 480,
   parameter int ADDR_W   = 19,
   parameter int RD_LAT   = 2,
   parameter int MAX_WAIT = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              wr_req,
   input  logic [9:0]        wr_x,
   input  logic [9:0]        wr_y,
   input  logic [7:0]        wr_val,
   output logic              wr_ack,
   output logic              wr_err,
   input  logic              rd_req,
   input  logic [9:0]        rd_x,
   input  logic [9:0]        rd_y,
   output logic [7:0]        rd_data,
   output logic              rd_valid,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   output logic              busy
);

   localparam int CNT_W = $clog2(RD_LAT + 1);
   localparam int STV_W = $clog2(MAX_WAIT + 1);
   localparam logic [10:0] C_WIDTH  = 11'(WIDTH);
   localparam logic [10:0] C_HEIGHT = 11'(HEIGHT);

   typedef enum logic [2:0] {
      S_IDLE, S_RD_WAIT, S_RD_DONE, S_RMW_RD, S_RMW_WAIT, S_RMW_WR, S_WR_ACK
   } state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [STV_W-1:0]   r_starve;
   logic [7:0]         r_val;
   logic               r_oob;
   logic               r_wr_ack;
   logic               r_wr_err;
   logic [7:0]         r_rd_data;
   logic               r_rd_valid;
   logic [ADDR_W-1:0]  r_mem_addr;
   logic               r_mem_we;
   logic [7:0]         r_mem_wdata;
   logic               r_busy;

   logic [ADDR_W-1:0]  w_rd_addr;
   logic [ADDR_W-1:0]  w_wr_addr;
   logic               w_rd_oob;
   logic               w_wr_oob;
   logic               w_rd_grant;
   logic [8:0]         w_sum;
   logic [7:0]         w_sat;

   assign w_rd_addr  = ADDR_W'(rd_y) * ADDR_W'(WIDTH) + ADDR_W'(rd_x);
   assign w_wr_addr  = ADDR_W'(wr_y) * ADDR_W'(WIDTH) + ADDR_W'(wr_x);
   assign w_rd_oob   = ({1'b0, rd_x} >= C_WIDTH) || ({1'b0, rd_y} >= C_HEIGHT);
   assign w_wr_oob   = ({1'b0, wr_x} >= C_WIDTH) || ({1'b0, wr_y} >= C_HEIGHT);
   assign w_rd_grant = rd_req && (!wr_req || (r_starve < STV_W'(MAX_WAIT)));

   // 9-bit signed sum overflows 8 bits exactly when its top two bits differ.
   assign w_sum = {mem_rdata[7], mem_rdata} + {r_val[7], r_val};
   assign w_sat = (w_sum[8] != w_sum[7]) ? (w_sum[8] ? 8'h80 : 8'h7F) : w_sum[7:0];

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_starve    <= '0;
         r_val       <= '0;
         r_oob       <= 1'b0;
         r_wr_ack    <= 1'b0;
         r_wr_err    <= 1'b0;
         r_rd_data   <= '0;
         r_rd_valid  <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_we    <= 1'b0;
         r_mem_wdata <= '0;
         r_busy      <= 1'b0;
      end else begin
         r_wr_ack   <= 1'b0;
         r_wr_err   <= 1'b0;
         r_rd_valid <= 1'b0;
         r_mem_we   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_rd_grant) begin
                  r_oob    <= w_rd_oob;
                  r_cnt    <= '0;
                  r_starve <= wr_req ? r_starve + 1'b1 : '0;
                  r_busy   <= 1'b1;
                  r_state  <= S_RD_WAIT;
                  if (!w_rd_oob) r_mem_addr <= w_rd_addr;
               end else if (wr_req) begin
                  r_starve <= '0;
                  r_val    <= wr_val;
                  r_oob    <= w_wr_oob;
                  r_busy   <= 1'b1;
                  if (w_wr_oob) begin
                     r_state <= S_WR_ACK;
                  end else begin
                     r_mem_addr <= w_wr_addr;
                     r_state    <= S_RMW_RD;
                  end
               end else begin
                  r_starve <= '0;
               end
            end
            S_RD_WAIT: begin
               if (r_cnt == CNT_W'(RD_LAT)) begin
                  r_rd_data <= r_oob ? 8'h00 : mem_rdata;
                  r_state   <= S_RD_DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_RD_DONE: begin
               r_rd_valid <= 1'b1;
               r_busy     <= 1'b0;
               r_state    <= S_IDLE;
            end
            S_RMW_RD: begin
               r_cnt   <= CNT_W'(1);
               r_state <= S_RMW_WAIT;
            end
            S_RMW_WAIT: begin
               if (r_cnt == CNT_W'(RD_LAT)) begin
                  r_mem_we    <= 1'b1;
                  r_mem_wdata <= w_sat;
                  r_state     <= S_RMW_WR;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_RMW_WR: begin
               r_state <= S_WR_ACK;
            end
            S_WR_ACK: begin
               r_wr_ack <= 1'b1;
               r_wr_err <= r_oob;
               r_busy   <= 1'b0;
               r_state  <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign wr_ack    = r_wr_ack;
   assign wr_err    = r_wr_err;
   assign rd_data   = r_rd_data;
   assign rd_valid  = r_rd_valid;
   assign mem_addr  = r_mem_addr;
   assign mem_we    = r_mem_we;
   assign mem_wdata = r_mem_wdata;
   assign busy      = r_busy;

endmodule

// File: tb/tb_heatmap_mem_arbiter.sv
// tb/tb_heatmap_mem_arbiter.sv - randomized bench for heatmap_mem_arbiter against a transaction-level model
`timescale 1ns/1ps
module tb_heatmap_mem_arbiter;

   localparam int WIDTH    = 640;
   localparam int HEIGHT   = 480;
   localparam int ADDR_W   = 19;
   localparam int RD_LAT   = 2;
   localparam int MAX_WAIT = 8;
   localparam int DEPTH    = WIDTH * HEIGHT;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              wr_req = 1'b0;
   logic [9:0]        wr_x = '0;
   logic [9:0]        wr_y = '0;
   logic [7:0]        wr_val = '0;
   logic              wr_ack;
   logic              wr_err;
   logic              rd_req = 1'b0;
   logic [9:0]        rd_x = '0;
   logic [9:0]        rd_y = '0;
   logic [7:0]        rd_data;
   logic              rd_valid;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata = '0;
   logic              busy;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clock = ~clock;

   heatmap_mem_arbiter #(
      .WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)
   ) dut (
      .clock(clock), .reset(reset),
      .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_val(wr_val),
      .wr_ack(wr_ack), .wr_err(wr_err),
      .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y),
      .rd_data(rd_data), .rd_valid(rd_valid),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   // Pixel memory with a two-stage read pipeline; preload port used only while the DUT is idle.
   logic [7:0] mem [int];
   logic [7:0] p1 = '0;
   logic       pl_en = 1'b0;
   int         pl_addr = 0;
   logic [7:0] pl_data = '0;

   function automatic logic [7:0] mem_get(input int a);
      return mem.exists(a) ? mem[a] : 8'h00;
   endfunction

   always @(posedge clock) begin
      p1        <= mem_get(int'(mem_addr));
      mem_rdata <= p1;
      if (pl_en) mem[pl_addr] = pl_data;
      else if (mem_we && int'(mem_addr) < DEPTH) mem[int'(mem_addr)] = mem_wdata;
   end

   int         we_cnt = 0;
   int         we_addr = 0;
   logic [7:0] we_data = '0;
   always @(negedge clock) begin
      if (mem_we) begin
         we_cnt  = we_cnt + 1;
         we_addr = int'(mem_addr);
         we_data = mem_wdata;
      end
   end

   // Reference model: signed pixel values, unwritten pixels read as 0.
   int model [int];

   function automatic int model_get(input int a);
      return model.exists(a) ? model[a] : 0;
   endfunction

   function automatic int sat_add(input int cur, input int inc);
      int s;
      s = cur + inc;
      if (s > 127) return 127;
      if (s < -128) return -128;
      return s;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic preload(input int x, input int y, input int v);
      @(negedge clock);
      pl_en   = 1'b1;
      pl_addr = y * WIDTH + x;
      pl_data = 8'(v);
      model[y * WIDTH + x] = v;
      @(negedge clock);
      pl_en = 1'b0;
   endtask

   task automatic do_write(input int x, input int y, input int val);
      bit         oob;
      bit         done;
      int         a, cyc, we0, e;
      logic       err;
      logic [7:0] e8;
      oob  = (x >= WIDTH) || (y >= HEIGHT);
      a    = y * WIDTH + x;
      we0  = we_cnt;
      wr_x = 10'(x); wr_y = 10'(y); wr_val = 8'(val); wr_req = 1'b1;
      cyc = 0; done = 0; err = 1'b0;
      while (!done && cyc < 40) begin
         @(posedge clock); cyc++; @(negedge clock);
         if (cyc == 1) check_eq("wr_busy", busy, 1);
         if (cyc == 2) begin
            wr_x = 10'($urandom); wr_y = 10'($urandom); wr_val = 8'($urandom);
         end
         if (wr_ack) begin done = 1; err = wr_err; end
      end
      wr_req = 1'b0;
      check_eq("wr_ack_seen", done, 1);
      check_eq("wr_latency", cyc - 1, oob ? 1 : RD_LAT + 3);
      check_eq("wr_err", err, oob);
      check_eq("wr_we_count", we_cnt - we0, oob ? 0 : 1);
      if (!oob) begin
         e  = sat_add(model_get(a), val);
         e8 = 8'(e);
         check_eq("wr_addr", we_addr, a);
         check_eq("wr_data", we_data, e8);
         model[a] = e;
      end
   endtask

   task automatic do_read(input int x, input int y);
      bit         oob;
      bit         done;
      int         a, cyc, we0;
      logic [7:0] got, e8;
      oob  = (x >= WIDTH) || (y >= HEIGHT);
      a    = y * WIDTH + x;
      we0  = we_cnt;
      e8   = oob ? 8'h00 : 8'(model_get(a));
      rd_x = 10'(x); rd_y = 10'(y); rd_req = 1'b1;
      cyc = 0; done = 0; got = '0;
      while (!done && cyc < 40) begin
         @(posedge clock); cyc++; @(negedge clock);
         if (cyc == 1 && !oob) check_eq("rd_addr", mem_addr, a);
         if (cyc == 2) begin rd_x = 10'($urandom); rd_y = 10'($urandom); end
         if (rd_valid) begin done = 1; got = rd_data; end
      end
      rd_req = 1'b0;
      check_eq("rd_valid_seen", done, 1);
      check_eq("rd_latency", cyc - 1, RD_LAT + 2);
      check_eq("rd_data", got, e8);
      check_eq("rd_no_we", we_cnt - we0, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_outs"},
               {wr_ack, wr_err, rd_valid, mem_we, busy, rd_data, mem_wdata},
               '0);
      check_eq({tag, "_addr"}, mem_addr, 0);
   endtask

   task automatic starvation_test();
      int         cyc, nrd, k, we0, a_r, a_w, e;
      bit         ack, got;
      logic [7:0] e_rd;
      a_r = 5 * WIDTH + 100;
      a_w = 6 * WIDTH + 200;
      e_rd = 8'(model_get(a_r));
      we0 = we_cnt;
      @(negedge clock);
      rd_x = 10'd100; rd_y = 10'd5; rd_req = 1'b1;
      wr_x = 10'd200; wr_y = 10'd6; wr_val = 8'd3; wr_req = 1'b1;
      cyc = 0; nrd = 0; ack = 0;
      while (!ack && cyc < 200) begin
         @(posedge clock); cyc++; @(negedge clock);
         if (rd_valid) begin
            nrd++;
            check_eq("stv_rd_data", rd_data, e_rd);
         end
         if (wr_ack) ack = 1;
      end
      wr_req = 1'b0;
      check_eq("stv_wr_ack_seen", ack, 1);
      check_eq("stv_reads_before_write", nrd, MAX_WAIT);
      e = sat_add(model_get(a_w), 3);
      check_eq("stv_we_count", we_cnt - we0, 1);
      check_eq("stv_wr_data", we_data, 8'(e));
      model[a_w] = e;
      k = 0; got = 0;
      while (!got && k < 20) begin
         @(posedge clock); k++; @(negedge clock);
         if (rd_valid) got = 1;
      end
      rd_req = 1'b0;
      check_eq("stv_read_resumes", got, 1);
      check_eq("stv_resume_latency", k, RD_LAT + 3);
   endtask

   task automatic reset_mid_rmw_test();
      int we0, acks;
      we0 = we_cnt;
      @(negedge clock);
      wr_x = 10'd7; wr_y = 10'd9; wr_val = 8'd10; wr_req = 1'b1;
      @(posedge clock);
      @(posedge clock);
      @(negedge clock);
      reset = 1'b1; wr_req = 1'b0;
      @(posedge clock); @(negedge clock);
      check_reset_outputs("rst_mid");
      reset = 1'b0;
      acks = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clock); @(negedge clock);
         if (wr_ack) acks++;
      end
      check_eq("rst_mid_no_ack", acks, 0);
      check_eq("rst_mid_no_we", we_cnt - we0, 0);
      do_write(7, 9, 10);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r, x, y, v;
      reset = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check_reset_outputs("reset");
      reset = 1'b0;

      do_write(3, 2, 5);
      preload(0, 0, 120);
      do_write(0, 0, 20);
      preload(0, 0, -100);
      do_write(0, 0, -50);
      preload(639, 479, 8'h2A);
      do_read(639, 479);
      do_write(640, 0, 5);
      do_read(0, 480);
      do_read(3, 2);

      starvation_test();
      reset_mid_rmw_test();

      for (int i = 0; i < 60; i++) begin
         r = int'($urandom_range(0, 15));
         if (r == 0) begin
            x = int'($urandom_range(WIDTH, 1023)); y = int'($urandom_range(0, HEIGHT - 1));
         end else if (r == 1) begin
            x = int'($urandom_range(0, WIDTH - 1)); y = int'($urandom_range(HEIGHT, 1023));
         end else if (r < 5) begin
            x = int'($urandom_range(0, WIDTH - 1)); y = int'($urandom_range(0, HEIGHT - 1));
         end else begin
            x = int'($urandom_range(0, 3)); y = int'($urandom_range(0, 3));
         end
         v = int'($urandom_range(0, 255)) - 128;
         if ($urandom_range(0, 1) == 0) do_write(x, y, v);
         else do_read(x, y);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
